// File: rtl/axil_reg_slave_if.sv
// AXI-Lite bus bundle between the register-bridge master and the register
// bank responder: 12-bit byte address, 32-bit data, byte strobes.
interface axil_reg_slave_if;
    logic [11:0] s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [11:0] s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid,
        output s_axil_awready,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_wready,
        output s_axil_bresp, s_axil_bvalid,
        input  s_axil_bready,
        input  s_axil_araddr, s_axil_arvalid,
        output s_axil_arready,
        output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  s_axil_rready
    );

    modport master (
        output s_axil_awaddr, s_axil_awvalid,
        input  s_axil_awready,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_wready,
        input  s_axil_bresp, s_axil_bvalid,
        output s_axil_bready,
        output s_axil_araddr, s_axil_arvalid,
        input  s_axil_arready,
        input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output s_axil_rready
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI-Lite register bank responder. AW and W are captured independently and
// merged into a single commit; only one write response is ever outstanding.
// Reads complete one cycle after the AR handshake and are independent of
// writes (a same-edge read/commit on one register sees the old value).
module axil_reg_slave #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     axil_aclk,
    input  logic                     axil_rst,
    axil_reg_slave_if.slave          bus,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic                     wr_pulse,
    output logic [9:0]               wr_idx
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic f_in_range(input logic [9:0] idx);
        return (int'(idx) < NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] f_slot(input logic [9:0] idx);
        return idx[IDX_W-1:0];
    endfunction

    logic        r_aw_full;
    logic [9:0]  r_aw_idx;
    logic        r_w_full;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] r_regs [NUM_REGS];
    logic        r_wr_pulse;
    logic [9:0]  r_wr_idx;

    logic        w_awready;
    logic        w_wready;
    logic        w_arready;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic        w_commit_ok;
    logic [9:0]  w_ar_idx;
    logic        w_ar_ok;
    logic        w_unused;

    // Readies are held low while reset is asserted and rise in the first
    // cycle after it; the byte-offset address bits are deliberately ignored.
    assign w_awready   = !axil_rst && !r_aw_full && !r_bvalid;
    assign w_wready    = !axil_rst && !r_w_full  && !r_bvalid;
    assign w_arready   = !axil_rst && !r_rvalid;
    assign w_aw_hs     = bus.s_axil_awvalid && w_awready;
    assign w_w_hs      = bus.s_axil_wvalid  && w_wready;
    assign w_ar_hs     = bus.s_axil_arvalid && w_arready;
    assign w_commit    = r_aw_full && r_w_full && !r_bvalid;
    assign w_commit_ok = w_commit && f_in_range(r_aw_idx);
    assign w_ar_idx    = bus.s_axil_araddr[11:2];
    assign w_ar_ok     = f_in_range(w_ar_idx);
    assign w_unused    = ^{bus.s_axil_awaddr[1:0], bus.s_axil_araddr[1:0]};

    assign bus.s_axil_awready = w_awready;
    assign bus.s_axil_wready  = w_wready;
    assign bus.s_axil_arready = w_arready;
    assign bus.s_axil_bvalid  = r_bvalid;
    assign bus.s_axil_bresp   = r_bresp;
    assign bus.s_axil_rvalid  = r_rvalid;
    assign bus.s_axil_rdata   = r_rdata;
    assign bus.s_axil_rresp   = r_rresp;
    assign wr_pulse           = r_wr_pulse;
    assign wr_idx             = r_wr_idx;

    genvar gk;
    generate
        for (gk = 0; gk < NUM_REGS; gk++) begin : g_flat
            assign regs_o[gk*32 +: 32] = r_regs[gk];
        end
    endgenerate

    // Hold slots for the write address and write data until both are present.
    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= bus.s_axil_awaddr[11:2];
            end else if (w_commit) begin
                r_aw_full <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= bus.s_axil_wdata;
                r_wstrb  <= bus.s_axil_wstrb;
            end else if (w_commit) begin
                r_w_full <= 1'b0;
            end
        end
    end

    // Write response: raised by a commit, held until the master takes it.
    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_commit_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_bvalid && bus.s_axil_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Register bank: byte-masked update on an in-range commit.
    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VAL;
            end
        end else if (w_commit_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_regs[f_slot(r_aw_idx)][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write-notify: one-cycle pulse and index of the last successful write.
    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= 10'd0;
        end else begin
            r_wr_pulse <= w_commit_ok;
            if (w_commit_ok) begin
                r_wr_idx <= r_aw_idx;
            end
        end
    end

    // Read path: capture data on AR handshake, hold until R handshake.
    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_ok ? r_regs[f_slot(w_ar_idx)] : 32'd0;
            r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && bus.s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based transaction model of the bank.
module tb_axil_reg_slave;

    localparam int          NUM = 16;
    localparam logic [31:0] RV  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_reg_slave_if bus();
    logic [NUM*32-1:0] regs_o;
    logic              wr_pulse;
    logic [9:0]        wr_idx;

    axil_reg_slave #(.NUM_REGS(NUM), .RESET_VAL(RV)) dut (
        .axil_aclk (clk),
        .axil_rst  (rst),
        .bus       (bus.slave),
        .regs_o    (regs_o),
        .wr_pulse  (wr_pulse),
        .wr_idx    (wr_idx)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [NUM*32-1:0] act, input logic [NUM*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake never completed (got none, required one)", name);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [NUM];
    logic [9:0]  m_aw_q [$];
    logic [35:0] m_w_q  [$];
    logic [1:0]  m_b_q  [$];
    logic [33:0] m_r_q  [$];
    logic        m_pulse = 1'b0;
    logic [9:0]  m_widx  = 10'd0;

    function automatic logic [NUM*32-1:0] m_flat();
        logic [NUM*32-1:0] f;
        for (int k = 0; k < NUM; k++) f[k*32 +: 32] = m_regs[k];
        return f;
    endfunction

    always @(posedge clk) begin
        bit awr, wr, arr;
        int idx;
        logic [35:0] wv;
        if (rst) begin
            m_aw_q.delete(); m_w_q.delete(); m_b_q.delete(); m_r_q.delete();
            for (int k = 0; k < NUM; k++) m_regs[k] = RV;
            m_pulse = 1'b0;
            m_widx  = 10'd0;
        end else begin
            awr = (m_aw_q.size() == 0) && (m_b_q.size() == 0);
            wr  = (m_w_q.size() == 0)  && (m_b_q.size() == 0);
            arr = (m_r_q.size() == 0);
            m_pulse = 1'b0;
            if (bus.s_axil_arvalid && arr) begin
                idx = int'(bus.s_axil_araddr[11:2]);
                if (idx < NUM) m_r_q.push_back({2'b00, m_regs[idx]});
                else           m_r_q.push_back({2'b10, 32'h0});
            end else if (m_r_q.size() != 0 && bus.s_axil_rready) begin
                void'(m_r_q.pop_front());
            end
            if (m_b_q.size() != 0) begin
                if (bus.s_axil_bready) void'(m_b_q.pop_front());
            end else if (m_aw_q.size() != 0 && m_w_q.size() != 0) begin
                idx = int'(m_aw_q.pop_front());
                wv  = m_w_q.pop_front();
                if (idx < NUM) begin
                    for (int b = 0; b < 4; b++)
                        if (wv[32+b]) m_regs[idx][b*8 +: 8] = wv[b*8 +: 8];
                    m_b_q.push_back(2'b00);
                    m_pulse = 1'b1;
                    m_widx  = 10'(idx);
                end else begin
                    m_b_q.push_back(2'b10);
                end
            end
            if (bus.s_axil_awvalid && awr) m_aw_q.push_back(bus.s_axil_awaddr[11:2]);
            if (bus.s_axil_wvalid && wr)   m_w_q.push_back({bus.s_axil_wstrb, bus.s_axil_wdata});
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        #3;
        if (chk_en) begin
            chk("awready", 32'(bus.s_axil_awready), 32'(!rst && m_aw_q.size() == 0 && m_b_q.size() == 0));
            chk("wready",  32'(bus.s_axil_wready),  32'(!rst && m_w_q.size() == 0 && m_b_q.size() == 0));
            chk("arready", 32'(bus.s_axil_arready), 32'(!rst && m_r_q.size() == 0));
            chk("bvalid",  32'(bus.s_axil_bvalid),  32'(m_b_q.size() != 0));
            if (m_b_q.size() != 0) chk("bresp", 32'(bus.s_axil_bresp), 32'(m_b_q[0]));
            chk("rvalid",  32'(bus.s_axil_rvalid),  32'(m_r_q.size() != 0));
            if (m_r_q.size() != 0) begin
                chk("rdata", bus.s_axil_rdata, m_r_q[0][31:0]);
                chk("rresp", 32'(bus.s_axil_rresp), 32'(m_r_q[0][33:32]));
            end
            chk("wr_pulse", 32'(wr_pulse), 32'(m_pulse));
            chk("wr_idx",   32'(wr_idx),   32'(m_widx));
            chkw("regs_o", regs_o, m_flat());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [11:0] a);
        bit ok = 1'b0;
        bus.s_axil_awaddr  = a;
        bus.s_axil_awvalid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = bus.s_axil_awready;
            tick();
        end
        bus.s_axil_awvalid = 1'b0;
        if (!ok) timeout("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        bus.s_axil_wdata  = d;
        bus.s_axil_wstrb  = s;
        bus.s_axil_wvalid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = bus.s_axil_wready;
            tick();
        end
        bus.s_axil_wvalid = 1'b0;
        if (!ok) timeout("w_handshake");
    endtask

    task automatic wait_b(input int dly);
        bit ok = 1'b0;
        repeat (dly) tick();
        bus.s_axil_bready = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = bus.s_axil_bvalid;
            tick();
        end
        bus.s_axil_bready = 1'b0;
        if (!ok) timeout("b_handshake");
    endtask

    task automatic do_read(input logic [11:0] a, input int dly,
                           output logic [31:0] d, output logic [1:0] r);
        bit ok = 1'b0;
        d = 32'hx;
        r = 2'bx;
        bus.s_axil_araddr  = a;
        bus.s_axil_arvalid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            ok = bus.s_axil_arready;
            tick();
        end
        bus.s_axil_arvalid = 1'b0;
        if (!ok) timeout("ar_handshake");
        repeat (dly) tick();
        ok = 1'b0;
        bus.s_axil_rready = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (bus.s_axil_rvalid) begin
                d  = bus.s_axil_rdata;
                r  = bus.s_axil_rresp;
                ok = 1'b1;
            end
            tick();
        end
        bus.s_axil_rready = 1'b0;
        if (!ok) timeout("r_handshake");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0]       rd, rd2;
        logic [1:0]        rr, rr2;
        logic [NUM*32-1:0] exp_flat;
        logic [11:0]       ra, wa;
        logic [31:0]       wd;
        logic [3:0]        ws;
        int                d1, d2, d3, db, dr;

        bus.s_axil_awaddr = '0; bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata  = '0; bus.s_axil_wstrb   = '0; bus.s_axil_wvalid = 1'b0;
        bus.s_axil_bready = 1'b0;
        bus.s_axil_araddr = '0; bus.s_axil_arvalid = 1'b0; bus.s_axil_rready = 1'b0;

        // reset state
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_awready", 32'(bus.s_axil_awready), 32'd0);
        chk("rst_arready", 32'(bus.s_axil_arready), 32'd0);
        chk("rst_rdata", bus.s_axil_rdata, 32'd0);
        chk("rst_bresp", 32'(bus.s_axil_bresp), 32'd0);
        chk("rst_wr_idx", 32'(wr_idx), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_awready", 32'(bus.s_axil_awready), 32'd1);
        chk("post_rst_wready",  32'(bus.s_axil_wready),  32'd1);
        tick();

        // AW and W together to 0x008
        fork
            send_aw(12'h008);
            send_w(32'hDEADBEEF, 4'hF);
        join
        tick();
        chk("t1_bvalid", 32'(bus.s_axil_bvalid), 32'd1);
        chk("t1_bresp", 32'(bus.s_axil_bresp), 32'd0);
        chk("t1_wr_pulse", 32'(wr_pulse), 32'd1);
        chk("t1_wr_idx", 32'(wr_idx), 32'd2);
        chk("t1_reg2", regs_o[95:64], 32'hDEADBEEF);
        wait_b(0);
        do_read(12'h008, 0, rd, rr);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_rresp", 32'(rr), 32'd0);

        // W three cycles ahead of AW, partial strobe
        send_w(32'h12345678, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            chk("t2_wready_low", 32'(bus.s_axil_wready), 32'd0);
            chk("t2_awready_high", 32'(bus.s_axil_awready), 32'd1);
            if (i < 2) tick();
        end
        send_aw(12'h004);
        wait_b(0);
        chk("t2_reg1", regs_o[63:32], 32'h00340078);

        // out-of-range write and read
        fork
            send_aw(12'h040);
            send_w(32'hFFFFFFFF, 4'hF);
        join
        tick();
        chk("t3_bresp", 32'(bus.s_axil_bresp), 32'd2);
        chk("t3_no_pulse", 32'(wr_pulse), 32'd0);
        exp_flat = '0;
        exp_flat[63:32] = 32'h00340078;
        exp_flat[95:64] = 32'hDEADBEEF;
        chkw("t3_regs_unchanged", regs_o, exp_flat);
        wait_b(0);
        do_read(12'h040, 0, rd, rr);
        chk("t3_rdata", rd, 32'd0);
        chk("t3_rresp", 32'(rr), 32'd2);

        // B held off for five cycles, second write waiting
        fork
            send_aw(12'h010);
            send_w(32'hCAFEF00D, 4'hF);
        join
        tick();
        bus.s_axil_awaddr = 12'h014; bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wdata = 32'h11112222; bus.s_axil_wstrb = 4'hF; bus.s_axil_wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_bvalid_hold", 32'(bus.s_axil_bvalid), 32'd1);
            chk("t4_bresp_hold", 32'(bus.s_axil_bresp), 32'd0);
            chk("t4_awready_low", 32'(bus.s_axil_awready), 32'd0);
            chk("t4_wready_low", 32'(bus.s_axil_wready), 32'd0);
            tick();
        end
        fork
            send_aw(12'h014);
            send_w(32'h11112222, 4'hF);
            wait_b(0);
        join
        wait_b(0);
        chk("t4_reg4", regs_o[159:128], 32'hCAFEF00D);
        chk("t4_reg5", regs_o[191:160], 32'h11112222);

        // read stalled while a write to the same register commits
        fork
            do_read(12'h00C, 4, rd, rr);
            begin
                fork
                    send_aw(12'h00C);
                    send_w(32'hA5A5A5A5, 4'hF);
                join
                wait_b(0);
            end
        join
        chk("t5_old_value", rd, 32'h0);
        do_read(12'h00E, 0, rd, rr);
        chk("t5_new_value", rd, 32'hA5A5A5A5);

        // reset between AW and W
        send_aw(12'h014);
        rst = 1'b1;
        #1;
        chk("t6_awready_in_rst", 32'(bus.s_axil_awready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_awready", 32'(bus.s_axil_awready), 32'd1);
        chk("t6_wready", 32'(bus.s_axil_wready), 32'd1);
        chk("t6_arready", 32'(bus.s_axil_arready), 32'd1);
        chk("t6_bvalid", 32'(bus.s_axil_bvalid), 32'd0);
        chkw("t6_regs_reset", regs_o, '0);
        tick();
        fork
            send_aw(12'h018);
            send_w(32'h0BADF00D, 4'hF);
        join
        wait_b(0);
        do_read(12'h018, 0, rd, rr);
        chk("t6_rdata", rd, 32'h0BADF00D);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            wa = 12'($urandom_range(0, 12'h05F));
            ra = 12'($urandom_range(0, 12'h05F));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            d1 = int'($urandom_range(0, 3));
            d2 = int'($urandom_range(0, 3));
            d3 = int'($urandom_range(0, 4));
            db = int'($urandom_range(0, 3));
            dr = int'($urandom_range(0, 3));
            fork
                begin
                    fork
                        begin repeat (d1) tick(); send_aw(wa); end
                        begin repeat (d2) tick(); send_w(wd, ws); end
                    join
                    wait_b(db);
                end
                begin repeat (d3) tick(); do_read(ra, dr, rd2, rr2); end
            join
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI-Lite responder: a bank of 32-bit read/write registers that answers the AXI-Lite master transactions issued by the register-bridge block.
- 12-bit byte address, 32-bit data, byte write strobes. Addresses beyond the bank return SLVERR.
- Register contents are exported as a flat bus. A one-cycle write-notify pulse lets downstream logic react to updates.

Parameters:
- NUM_REGS, 16: number of 32-bit registers; legal range 1..1024; word index = addr[11:2].
- RESET_VAL, 32'h0: reset value loaded into every register.

Ports:
- axil_aclk  input  1  single clock for all logic.
- axil_rst  input  1  reset; synchronous, active-high.
- s_axil_awaddr  input  12  write byte address.
- s_axil_awvalid  input  1  write address valid.
- s_axil_awready  output  1  write address ready.
- s_axil_wdata  input  32  write data.
- s_axil_wstrb  input  4  byte enables.
- s_axil_wvalid  input  1  write data valid.
- s_axil_wready  output  1  write data ready.
- s_axil_bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axil_bvalid  output  1  write response valid.
- s_axil_bready  input  1  write response ready.
- s_axil_araddr  input  12  read byte address.
- s_axil_arvalid  input  1  read address valid.
- s_axil_arready  output  1  read address ready.
- s_axil_rdata  output  32  read data.
- s_axil_rresp  output  2  read response: OKAY or SLVERR.
- s_axil_rvalid  output  1  read data valid.
- s_axil_rready  input  1  read data ready.
- regs_o  output  NUM_REGS*32  register contents; register k occupies bits [k*32+:32].
- wr_pulse  output  1  one-cycle pulse when a register write commits.
- wr_idx  output  10  word index of the last committed write; valid while wr_pulse=1.

Behaviour:
- Reset (axil_rst=1 at a clock edge):
  - all registers = RESET_VAL;
  - awready = wready = arready = 0 during reset, 1 on the first cycle after reset;
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; wr_pulse = 0; wr_idx = 0.
- Reset mid-transaction discards any held AW/W and any pending B/R response. No register update occurs.
- Write path, AW and W handled independently:
  - AW accepted on (awvalid & awready); address latched into aw_hold, aw_full set. awready = !aw_full & !bvalid.
  - W accepted on (wvalid & wready); data and strobe latched, w_full set. wready = !w_full & !bvalid.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
- Commit happens on the edge where aw_full & w_full & !bvalid:
  - if the index < NUM_REGS, each byte i with wstrb[i]=1 is updated; bresp = OKAY;
  - otherwise no update and bresp = SLVERR;
  - bvalid is set and aw_full/w_full are cleared;
  - wr_pulse = 1 for exactly one cycle, only on an OKAY commit; wr_idx is updated on OKAY commits only.
- Write latency: AW+W handshake at edge N -> register update and bvalid at edge N+1.
- bvalid holds with stable bresp until bready; it clears on (bvalid & bready). No new AW/W is accepted while bvalid=1, so at most one write is outstanding.
- Read path:
  - arready = !rvalid.
  - On (arvalid & arready), at the same edge: rdata = register value (0 if out of range), rresp = OKAY or SLVERR, rvalid = 1.
  - Read latency is 1 cycle. rdata/rresp are held stable until (rvalid & rready), after which rvalid = 0.
  - Back-to-back reads are possible when rready stays high: arready returns to 1 in the cycle after the R handshake.
- addr[1:0] is ignored; unaligned addresses map to the containing word.
- Read and write paths are fully independent. If a read handshake and a write commit hit the same register on the same edge, the read returns the pre-write value.
- wstrb = 4'b0000 to a valid address: no bytes change, bresp = OKAY, wr_pulse still fires.
- regs_o reflects the new values from the cycle after commit.

Test Plan:
- Reset, then write addr 0x008, data 0xDEADBEEF, wstrb 4'hF, AW and W in the same cycle -> bvalid one cycle later with bresp=00, wr_pulse=1, wr_idx=2, regs_o[95:64]=0xDEADBEEF; read 0x008 -> rdata=0xDEADBEEF, rresp=00, rvalid one cycle after the AR handshake.
- W sent 3 cycles before AW (addr 0x004, data 0x12345678, wstrb 4'b0101) onto register holding 0 -> register = 0x00340078; awready stays high until AW arrives; wready low after W is accepted.
- Write to addr 0x040 (index 16, out of range) data 0xFFFFFFFF -> bresp=10, no wr_pulse, all regs unchanged; read 0x040 -> rdata=0, rresp=10.
- bready held low for 5 cycles after a write -> bvalid and bresp stable; awready = wready = 0 throughout; second AW/W is accepted only after the B handshake.
- Read of 0x00C with rready low for 4 cycles while a write of 0xA5A5A5A5 to 0x00C commits -> rdata keeps the old value; a subsequent read returns 0xA5A5A5A5.
- Assert axil_rst one cycle after AW is accepted but before W -> after reset, no register changes, bvalid=0, all readies=1; a fresh complete write succeeds normally.
